// File: rtl/uart_alu_sequencer_if.sv
// Handshake bundle between the UART rx/tx, the ALU and the command sequencer.
// The sequencer takes the slave side; whatever drives the UART/ALU side takes the master side.
interface uart_alu_sequencer_if #(
  parameter int DBIT = 8
);
  logic                   rx_done_tick;
  logic [DBIT-1:0]        rx_data;
  logic                   tx_done_tick;
  logic [DBIT-1:0]        alu_result;
  logic signed [DBIT-1:0] a;
  logic signed [DBIT-1:0] b;
  logic [5:0]             op;
  logic [DBIT-1:0]        tx_data;
  logic                   tx_start;
  logic                   busy;
  logic                   overrun;

  modport master (
    output rx_done_tick, rx_data,
    output tx_done_tick, alu_result,
    input  a, b, op, tx_data,
    input  tx_start, busy, overrun
  );

  modport slave (
    input  rx_done_tick, rx_data,
    input  tx_done_tick, alu_result,
    output a, b, op, tx_data,
    output tx_start, busy, overrun
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects an (A, B, opcode) frame from the UART receiver, runs it through the
// registered ALU and hands exactly one result (or error) byte to the transmitter.
module uart_alu_sequencer #(
  parameter int              DBIT     = 8,
  parameter int              ALU_LAT  = 2,
  parameter int              TIMEOUT  = 1000000,
  parameter logic [DBIT-1:0] ERR_CODE = 8'hFF
) (
  input logic              clk,
  input logic              reset,
  uart_alu_sequencer_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LMAX = LW'(ALU_LAT);
  localparam logic [5:0]    OP_ADD = 6'b100000;

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    GET_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [5:0]      op_q, op_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            op_ok;
  logic            tick;
  logic            in_exec;

  assign tick = bus.rx_done_tick;

  always_comb begin
    op_ok = 1'b0;
    if ((bus.rx_data >> 6) == '0) begin
      case (bus.rx_data[5:0])
        6'b100000, 6'b100010,
        6'b100100, 6'b100101,
        6'b100110, 6'b100111,
        6'b000011, 6'b000010: op_ok = 1'b1;
        default:              op_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    ovr_d     = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          a_d     = bus.rx_data;
          tmo_d   = '0;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (tick) begin
          b_d     = bus.rx_data;
          tmo_d   = '0;
          state_d = GET_OP;
        end else if (tmo_q == TMAX) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GET_OP: begin
        if (tick) begin
          tmo_d = '0;
          if (op_ok) begin
            op_d    = bus.rx_data[5:0];
            lat_d   = '0;
            state_d = EXEC;
          end else begin
            tx_data_d = ERR_CODE;
            state_d   = SEND;
          end
        end else if (tmo_q == TMAX) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EXEC: begin
        if (lat_q == LMAX) begin
          tx_data_d = bus.alu_result;
          state_d   = SEND;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.tx_done_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // bytes arriving while a frame is in flight are lost
    in_exec = (state_q == EXEC) || (state_q == SEND) ||
              (state_q == WAIT_TX);
    if (tick && in_exec) ovr_d = 1'b1;
    tx_start_d = (state_d == SEND);
    busy_d     = (state_d == EXEC) || (state_d == SEND) ||
                 (state_d == WAIT_TX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.op       = op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Command sequencer between the UART receive/transmit modules and the ALU. It collects a 3-byte frame from the UART receiver (operand A, operand B, opcode) and drives the ALU operands and opcode. It then waits out the ALU's registered latency, captures the result, and hands exactly one result byte to the UART transmitter. It adds an inter-byte timeout, opcode validation with an error reply, and overrun detection.

Parameters:
DBIT, 8, data/operand width in bits
ALU_LAT, 2, clk cycles from stable a/b/op to valid alu_result (ALU output is registered)
TIMEOUT, 1000000, clk cycles allowed between frame bytes before the partial frame is discarded
ERR_CODE, 8'hFF, byte transmitted when the opcode is invalid

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
rx_done_tick  input  1  one-cycle pulse, rx_data valid
rx_data  input  DBIT  received byte
tx_done_tick  input  1  one-cycle pulse, transmitter finished the byte
alu_result  input  DBIT  ALU output
a  output  DBIT  signed operand A to ALU
b  output  DBIT  signed operand B to ALU
op  output  6  ALU opcode
tx_data  output  DBIT  byte to transmit, held stable from tx_start until tx_done_tick
tx_start  output  1  one-cycle transmit request
busy  output  1  high in EXEC, SEND, WAIT_TX
overrun  output  1  sticky, byte received while busy

Behaviour:
- Reset (reset=0, async): state=IDLE; a=0, b=0, op=6'b100000 (ADD); tx_data=0; tx_start=0; busy=0; overrun=0; timeout counter=0.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: on rx_done_tick, a<=rx_data, go to GET_B, clear timeout counter.
- GET_B: on rx_done_tick, b<=rx_data, go to GET_OP, clear counter. Otherwise the counter increments; at TIMEOUT-1, go to IDLE. a keeps the new value.
- GET_OP: on rx_done_tick, validate the byte. Valid means upper DBIT-6 bits are 0 and [5:0] is in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL}.
  - Valid: op<=rx_data[5:0], go to EXEC with the latency counter at 0.
  - Invalid: op unchanged, tx_data<=ERR_CODE, go to SEND (EXEC skipped).
  - Timeout handling as in GET_B.
- A rx_done_tick on the same cycle as timeout expiry: the byte wins (accepted, no timeout).
- EXEC: counter increments each clk. When it reaches ALU_LAT, tx_data<=alu_result and go to SEND. Total latency from the opcode tick to tx_start high is ALU_LAT+2 cycles.
- SEND: tx_start=1 for exactly this one cycle, then WAIT_TX. tx_start is registered and Moore-decoded.
- WAIT_TX: stay until tx_done_tick, then IDLE. tx_data holds its value.
- Any rx_done_tick in EXEC/SEND/WAIT_TX is dropped and sets overrun=1. overrun clears only on reset.
- rx_done_tick on the same cycle as tx_done_tick in WAIT_TX: byte dropped, overrun set, state goes to IDLE. The next frame starts with the following byte.
- a/b/op never change outside IDLE/GET_B/GET_OP byte acceptance, so the ALU inputs are stable during EXEC.
- Reset asserted mid-frame or mid-transmit: immediate return to reset values. No tx_start is issued after reset release until a new full frame arrives.
- Counters are sized ceil(log2(TIMEOUT)) and ceil(log2(ALU_LAT+1)). No wrap occurs because each counter is cleared on every state entry.

Test Plan:
1. Bytes 0x05, 0x03, 0x20 (ADD); model ALU returns 0x08 after 2 cycles -> a=5, b=3, op=100000; tx_start pulses once, 4 cycles after the third tick, with tx_data=0x08; busy=1 until tx_done_tick, then IDLE.
2. Bytes 0xF0, 0x02, 0x03 (SRA) -> op=000011, tx_data equals the ALU output (0xFC from the model); a is read as signed -16.
3. Bytes 0x01, 0x01, 0x3F -> invalid opcode; no EXEC; tx_start with tx_data=0xFF; op keeps its previous value. Byte 0x60 (upper bits set) also yields 0xFF.
4. TIMEOUT=16 override: send 0x07, then nothing for 16 cycles, then bytes 0x01, 0x02, 0x22 -> the first byte is discarded; the frame is a=1, b=2, SUB.
5. Send a 4th byte 0xAA during WAIT_TX, and separately on the same cycle as tx_done_tick -> overrun=1 (sticky), no extra tx_start, and the next clean frame completes normally.
6. Assert reset low during EXEC -> all outputs return to reset values asynchronously; no tx_start after release; overrun=0.
